// File: rtl/adder_mp_seq_pkg.sv
// Shared types and helpers for the multi-precision adder sequencer.
package adder_mp_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Word-index counter width: clog2 with a floor of one bit.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/adder_mp_seq_word_adder.sv
// Combinational N-bit carry-lookahead word adder shared by the sequencer.
module word_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  always_comb begin
    gen      = a & b;
    prop     = a | b;
    carry    = '0;
    carry[0] = ci;
    for (int unsigned i = 0; i < N; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    // prop is a|b, so the sum bit needs the true xor, not prop.
    s  = a ^ b ^ carry[N-1:0];
    co = carry[N];
  end

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision adder: one shared N-bit word adder, one word per cycle, LSW first.
module adder_mp_seq
  import adder_mp_seq_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               ci,
  output logic [N*WORDS-1:0] s,
  output logic               co,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IdxW = idx_width(WORDS);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            co_q, co_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [N-1:0] a_word, b_word, sum_word;
  logic         carry_word;
  logic         accept;
  logic         last;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (idx_q == IdxW'(WORDS - 1));

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_word = a_q[i*N +: N];
        b_word = b_q[i*N +: N];
      end
    end
  end

  word_adder #(
    .N (N)
  ) u_word_adder (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (sum_word),
    .co (carry_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    s    = s_q;
    co   = co_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      s_d     = '0;
      carry_d = ci;
      co_d    = 1'b0;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      carry_d = carry_word;
      // Wrap to zero on the last word so idx never exceeds WORDS-1.
      idx_d   = last ? '0 : idx_q + 1'b1;
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx_q == IdxW'(i)) s_d[i*N +: N] = sum_word;
      end
      if (last) co_d = carry_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
    end
  end

endmodule
